// File: rtl/serial_bus_arbiter_n.sv
// N-master serial bus arbiter: start-bit detection, fixed/round-robin grant,
// MSB-first address deserialisation and slave-response timeout.
module serial_bus_arbiter_n #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 14,
    parameter int RR_MODE     = 0,
    parameter int TIMEOUT     = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         m_tx,
    output logic [NUM_MASTERS-1:0]         m_rx,
    input  logic                           s_rx,
    output logic                           bus_tx,
    output logic [NUM_MASTERS-1:0]         grant,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
    output logic [ADDR_WIDTH-1:0]          addr,
    output logic                           addr_rdy,
    input  logic                           slv_ready,
    input  logic                           xfer_done,
    output logic                           addr_err,
    output logic                           busy
);

    localparam int GW = $clog2(NUM_MASTERS);
    localparam int BW = $clog2(ADDR_WIDTH + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, WAIT_SLV, CONNECTED} state_t;

    state_t                  state_q, state_d;
    logic [NUM_MASTERS-1:0]  grant_q, grant_d;
    logic [GW-1:0]           gid_q, gid_d;
    logic [GW-1:0]           last_q, last_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-2:0]   sh_q, sh_d;
    logic                    rdy_q, rdy_d;
    logic                    err_q, err_d;
    logic [BW-1:0]           bcnt_q, bcnt_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;

    logic [NUM_MASTERS-1:0]  req;
    logic [GW-1:0]           win;
    logic                    found;
    logic [ADDR_WIDTH-1:0]   shifted;

    // Winner search: RR rotates the starting point to just past the last grant.
    always_comb begin
        int unsigned idx;
        req   = ~m_tx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (RR_MODE != 0)
                idx = (int'(last_q) + 1 + k) % NUM_MASTERS;
            else
                idx = k;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        last_d  = last_q;
        addr_d  = addr_q;
        sh_d    = sh_q;
        rdy_d   = 1'b0;
        err_d   = 1'b0;
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;
        shifted = {sh_q, m_tx[gid_q]};
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    gid_d        = win;
                    bcnt_d       = '0;
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                sh_d   = shifted[ADDR_WIDTH-2:0];
                bcnt_d = bcnt_q + 1'b1;
                if (int'(bcnt_q) == ADDR_WIDTH - 1) begin
                    addr_d  = shifted;
                    rdy_d   = 1'b1;
                    tcnt_d  = '0;
                    state_d = WAIT_SLV;
                end
            end
            WAIT_SLV: begin
                // slv_ready takes precedence over a timeout firing in the same cycle.
                if (slv_ready) begin
                    state_d = CONNECTED;
                end else if (TIMEOUT != 0) begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (int'(tcnt_q) + 1 == TIMEOUT) begin
                        err_d   = 1'b1;
                        grant_d = '0;
                        gid_d   = '0;
                        last_d  = gid_q;
                        state_d = IDLE;
                    end
                end
            end
            CONNECTED: begin
                if (xfer_done) begin
                    grant_d = '0;
                    gid_d   = '0;
                    last_d  = gid_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            last_q  <= GW'(NUM_MASTERS - 1);
            addr_q  <= '0;
            sh_q    <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            sh_q    <= sh_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = gid_q;
    assign addr     = addr_q;
    assign addr_rdy = rdy_q;
    assign addr_err = err_q;
    assign busy     = (state_q != IDLE);
    assign bus_tx   = (|grant_q) ? m_tx[gid_q] : 1'b1;
    assign m_rx     = ~grant_q | {NUM_MASTERS{s_rx}};

endmodule

// File: tb/tb_serial_bus_arbiter_n.sv
// Directed bench for serial_bus_arbiter_n: a fixed-priority and a round-robin
// instance share stimulus; each scenario checks the instance selected by 'sel'.
module tb_serial_bus_arbiter_n;

    localparam int N  = 4;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  m_tx;
    logic          s_rx;
    logic          slv_ready;
    logic          xfer_done;
    logic          sel;

    logic [N-1:0]  m_rx_f, m_rx_r, grant_f, grant_r;
    logic          bus_tx_f, bus_tx_r, rdy_f, rdy_r, err_f, err_r, busy_f, busy_r;
    logic [1:0]    gid_f, gid_r;
    logic [AW-1:0] addr_f, addr_r;

    logic [N-1:0]  m_rx_c, grant_c;
    logic          bus_tx_c, rdy_c, err_c, busy_c;
    logic [1:0]    gid_c;
    logic [AW-1:0] addr_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_bus_arbiter_n #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .RR_MODE(0), .TIMEOUT(8)) u_fix (
        .clk(clk), .rst(rst), .m_tx(m_tx), .m_rx(m_rx_f), .s_rx(s_rx), .bus_tx(bus_tx_f),
        .grant(grant_f), .grant_id(gid_f), .addr(addr_f), .addr_rdy(rdy_f),
        .slv_ready(slv_ready), .xfer_done(xfer_done), .addr_err(err_f), .busy(busy_f));

    serial_bus_arbiter_n #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .RR_MODE(1), .TIMEOUT(8)) u_rr (
        .clk(clk), .rst(rst), .m_tx(m_tx), .m_rx(m_rx_r), .s_rx(s_rx), .bus_tx(bus_tx_r),
        .grant(grant_r), .grant_id(gid_r), .addr(addr_r), .addr_rdy(rdy_r),
        .slv_ready(slv_ready), .xfer_done(xfer_done), .addr_err(err_r), .busy(busy_r));

    always_comb begin
        m_rx_c   = sel ? m_rx_r   : m_rx_f;
        grant_c  = sel ? grant_r  : grant_f;
        bus_tx_c = sel ? bus_tx_r : bus_tx_f;
        rdy_c    = sel ? rdy_r    : rdy_f;
        err_c    = sel ? err_r    : err_f;
        busy_c   = sel ? busy_r   : busy_f;
        gid_c    = sel ? gid_r    : gid_f;
        addr_c   = sel ? addr_r   : addr_f;
    end

    typedef struct {
        logic [N-1:0] mtx;
        logic         srx;
        logic         exp_bus;
        logic [N-1:0] exp_mrx;
    } route_vec_t;

    typedef struct {
        int unsigned   exp_id;
        logic [AW-1:0] a;
    } rr_vec_t;

    route_vec_t route_tab[4];
    rr_vec_t    rr_tab[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_grant"},   32'(grant_c),  32'h0);
        chk({tag, "_gid"},     32'(gid_c),    32'h0);
        chk({tag, "_addr"},    32'(addr_c),   32'h0);
        chk({tag, "_rdy"},     32'(rdy_c),    32'h0);
        chk({tag, "_err"},     32'(err_c),    32'h0);
        chk({tag, "_busy"},    32'(busy_c),   32'h0);
        chk({tag, "_bus_tx"},  32'(bus_tx_c), 32'h1);
        chk({tag, "_m_rx"},    32'(m_rx_c),   32'hF);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_tx = '1;
        tick();
        rst = 1'b0;
    endtask

    // Shift address MSB first on master m; returns just after the edge that samples bit 0.
    task automatic do_addr(input int unsigned m, input logic [AW-1:0] a);
        for (int i = AW - 1; i >= 0; i--) begin
            m_tx[m] = a[i];
            tick();
        end
        m_tx[m] = 1'b1;
    endtask

    task automatic finish_xact(input string tag);
        slv_ready = 1'b1;
        tick();
        slv_ready = 1'b0;
        chk({tag, "_conn_busy"}, 32'(busy_c), 32'h1);
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        chk({tag, "_rel_grant"}, 32'(grant_c), 32'h0);
        chk({tag, "_rel_busy"},  32'(busy_c),  32'h0);
    endtask

    initial begin
        route_tab[0] = '{mtx: 4'b1110, srx: 1'b0, exp_bus: 1'b0, exp_mrx: 4'b1110};
        route_tab[1] = '{mtx: 4'b1111, srx: 1'b1, exp_bus: 1'b1, exp_mrx: 4'b1111};
        route_tab[2] = '{mtx: 4'b0001, srx: 1'b0, exp_bus: 1'b1, exp_mrx: 4'b1110};
        route_tab[3] = '{mtx: 4'b0000, srx: 1'b1, exp_bus: 1'b0, exp_mrx: 4'b1111};

        rr_tab[0] = '{exp_id: 0, a: 14'h0123};
        rr_tab[1] = '{exp_id: 1, a: 14'h3FFF};
        rr_tab[2] = '{exp_id: 2, a: 14'h1555};
        rr_tab[3] = '{exp_id: 3, a: 14'h2AAA};
        rr_tab[4] = '{exp_id: 0, a: 14'h0001};

        sel = 1'b0; s_rx = 1'b1; slv_ready = 1'b0; xfer_done = 1'b0;
        rst = 1'b1; m_tx = '1;
        tick(); tick();
        rst = 1'b0;
        chk_reset("por");

        // Single request on m0 with address 2A5C
        m_tx = 4'b1110;
        tick();
        chk("single_grant", 32'(grant_c), 32'h1);
        chk("single_busy",  32'(busy_c),  32'h1);
        do_addr(0, 14'h2A5C);
        chk("single_rdy",  32'(rdy_c),  32'h1);
        chk("single_addr", 32'(addr_c), 32'h2A5C);
        tick();
        chk("single_rdy_pulse", 32'(rdy_c), 32'h0);
        slv_ready = 1'b1;
        tick();
        slv_ready = 1'b0;
        chk("single_conn", 32'(busy_c), 32'h1);
        for (int unsigned i = 0; i < 4; i++) begin
            m_tx = route_tab[i].mtx;
            s_rx = route_tab[i].srx;
            #1;
            chk($sformatf("route%0d_bus_tx", i), 32'(bus_tx_c), 32'(route_tab[i].exp_bus));
            chk($sformatf("route%0d_m_rx", i),   32'(m_rx_c),   32'(route_tab[i].exp_mrx));
        end
        m_tx = '1; s_rx = 1'b1;
        repeat (13) tick();
        chk("single_held", 32'(grant_c), 32'h1);
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        chk("single_release", 32'(grant_c), 32'h0);
        chk("single_rel_busy", 32'(busy_c), 32'h0);

        // Fixed priority: m1 and m3 start together
        m_tx = 4'b0101;
        tick();
        chk("fix_grant_m1", 32'(grant_c), 32'h2);
        chk("fix_gid_m1",   32'(gid_c),   32'h1);
        do_addr(1, 14'h0ABC);
        chk("fix_addr_m1", 32'(addr_c), 32'h0ABC);
        finish_xact("fix_m1");
        tick();
        chk("fix_grant_m3", 32'(grant_c), 32'h8);
        chk("fix_gid_m3",   32'(gid_c),   32'h3);
        do_addr(3, 14'h3C3C);
        chk("fix_addr_m3", 32'(addr_c), 32'h3C3C);
        finish_xact("fix_m3");

        // Round-robin: all four continuously requesting
        sel = 1'b1;
        do_reset();
        chk_reset("rr_rst");
        m_tx = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rr%0d_gid", i),   32'(gid_c),   32'(rr_tab[i].exp_id));
            chk($sformatf("rr%0d_grant", i), 32'(grant_c), 32'(1 << rr_tab[i].exp_id));
            do_addr(rr_tab[i].exp_id, rr_tab[i].a);
            chk($sformatf("rr%0d_addr", i), 32'(addr_c), 32'(rr_tab[i].a));
            slv_ready = 1'b1;
            tick();
            slv_ready = 1'b0;
            m_tx[rr_tab[i].exp_id] = 1'b0;
            xfer_done = 1'b1;
            tick();
            xfer_done = 1'b0;
            chk($sformatf("rr%0d_release", i), 32'(grant_c), 32'h0);
        end

        // Timeout in RR mode: m0 and m2 pending, m0 times out and retries
        do_reset();
        m_tx = 4'b1010;
        tick();
        chk("to_grant_m0", 32'(grant_c), 32'h1);
        do_addr(0, 14'h1111);
        chk("to_rdy", 32'(rdy_c), 32'h1);
        m_tx[0] = 1'b0;
        for (int unsigned i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("to_wait%0d_err", i),   32'(err_c),   32'h0);
            chk($sformatf("to_wait%0d_grant", i), 32'(grant_c), 32'h1);
        end
        tick();
        chk("to_err",        32'(err_c),   32'h1);
        chk("to_grant_drop", 32'(grant_c), 32'h0);
        chk("to_busy_drop",  32'(busy_c),  32'h0);
        tick();
        chk("to_err_pulse",  32'(err_c),   32'h0);
        chk("to_next_m2",    32'(grant_c), 32'h4);
        do_addr(2, 14'h2222);
        chk("to_addr_m2", 32'(addr_c), 32'h2222);
        finish_xact("to_m2");

        // Collision: slv_ready on the exact timeout cycle (fixed instance)
        sel = 1'b0;
        do_reset();
        m_tx = 4'b1110;
        tick();
        do_addr(0, 14'h0F0F);
        repeat (7) tick();
        slv_ready = 1'b1;
        tick();
        slv_ready = 1'b0;
        chk("col_no_err", 32'(err_c),   32'h0);
        chk("col_grant",  32'(grant_c), 32'h1);
        tick();
        chk("col_no_err_late", 32'(err_c),  32'h0);
        chk("col_connected",   32'(busy_c), 32'h1);
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        chk("col_release", 32'(grant_c), 32'h0);

        // Reset in the middle of an address
        m_tx = 4'b1101;
        tick();
        chk("mid_grant", 32'(grant_c), 32'h2);
        for (int unsigned i = 0; i < 5; i++) begin
            m_tx[1] = i[0];
            tick();
        end
        do_reset();
        chk_reset("mid_rst");
        m_tx[1] = 1'b0;
        tick();
        chk("mid_regrant", 32'(grant_c), 32'h2);
        do_addr(1, 14'h1234);
        chk("mid_rdy",  32'(rdy_c),  32'h1);
        chk("mid_addr", 32'(addr_c), 32'h1234);
        finish_xact("mid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
